// File: rtl/memcic_interp.sv
// CIC interpolator; comb delays and integrators share one synchronous-read RAM. MEMCIC_INTERP_STATUS_EN adds sticky status.
// out_strobe STAGES+3 cycles after an idle out_req; single-entry pending slots, newer sample / extra request overwrites or drops.
module memcic_interp #(
   parameter int STAGES        = 5,
   parameter int INTERPOLATION = 20,
   parameter int ACC_WIDTH     = 72
) (
   input  logic               clock,
   input  logic               reset_n,
   input  logic               in_strobe,
   input  logic signed [23:0] in_data,
   input  logic               out_req,
   output logic               out_strobe,
   output logic signed [23:0] out_data,
   output logic               busy
`ifdef MEMCIC_INTERP_STATUS_EN
   ,
   input  logic               status_clr,
   output logic [1:0]         status
`endif
);

   localparam int         AW        = ACC_WIDTH;
   localparam logic [4:0] LAST_STG  = 5'(STAGES - 1);
   localparam logic [4:0] LAST_INIT = 5'(2 * STAGES - 1);
   localparam logic [4:0] NUM_STG   = 5'(STAGES);
   localparam logic [4:0] INTG_BASE = 5'd16;

   if (STAGES < 1 || STAGES > 16 || INTERPOLATION < 2 || INTERPOLATION > 255 ||
       ACC_WIDTH < 25 || ACC_WIDTH > 72) begin : g_bad_params
      $error("memcic_interp: parameter out of range");
   end

   typedef enum logic [2:0] {
      S_INIT, S_IDLE, S_COMB_RD, S_COMB_RUN, S_INTG_RD, S_INTG_RUN, S_OUT
   } state_t;

   state_t               state_q, state_d;
   logic [4:0]           cnt_q, cnt_d;
   logic [AW-1:0]        mem [0:31];
   logic [AW-1:0]        rd_dat, x_q, wr_dat, comb_y, intg_sum;
   logic [4:0]           rd_addr, wr_addr;
   logic                 wr_en, comb_start, comb_done, intg_start, out_load;
   logic signed [23:0]   in_dat_q;
   logic                 in_pend_q, req_pend_q, stuff_q;
   logic                 in_take, req_take;

   assign comb_y   = x_q - rd_dat;
   assign intg_sum = rd_dat + x_q;
   assign in_take  = in_strobe && (state_q != S_INIT);
   assign req_take = out_req && (state_q != S_INIT);
   assign busy     = (state_q != S_IDLE);

   always_ff @(posedge clock) begin
      if (wr_en) mem[wr_addr] <= wr_dat;
      rd_dat <= mem[rd_addr];
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) state_q <= S_INIT;
      else          state_q <= state_d;
   end

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      wr_en      = 1'b0;
      wr_addr    = '0;
      wr_dat     = '0;
      rd_addr    = '0;
      comb_start = 1'b0;
      comb_done  = 1'b0;
      intg_start = 1'b0;
      out_load   = 1'b0;
      case (state_q)
         S_INIT: begin
            wr_en   = 1'b1;
            wr_addr = (cnt_q < NUM_STG) ? cnt_q : (cnt_q - NUM_STG + INTG_BASE);
            cnt_d   = cnt_q + 5'd1;
            if (cnt_q == LAST_INIT) begin
               cnt_d   = '0;
               state_d = S_IDLE;
            end
         end
         S_IDLE: begin
            // A pending input always goes through the combs before the next output
            if (in_pend_q) begin
               comb_start = 1'b1;
               state_d    = S_COMB_RD;
            end else if (req_pend_q) begin
               intg_start = 1'b1;
               state_d    = S_INTG_RD;
            end
         end
         S_COMB_RD: begin
            cnt_d   = '0;
            state_d = S_COMB_RUN;
         end
         S_COMB_RUN: begin
            rd_addr = cnt_q + 5'd1;
            wr_en   = 1'b1;
            wr_addr = cnt_q;
            wr_dat  = x_q;
            cnt_d   = cnt_q + 5'd1;
            if (cnt_q == LAST_STG) begin
               comb_done = 1'b1;
               state_d   = S_IDLE;
            end
         end
         S_INTG_RD: begin
            rd_addr = INTG_BASE;
            cnt_d   = '0;
            state_d = S_INTG_RUN;
         end
         S_INTG_RUN: begin
            rd_addr = INTG_BASE + cnt_q + 5'd1;
            wr_en   = 1'b1;
            wr_addr = INTG_BASE + cnt_q;
            wr_dat  = intg_sum;
            cnt_d   = cnt_q + 5'd1;
            if (cnt_q == LAST_STG) begin
               out_load = 1'b1;
               state_d  = S_OUT;
            end
         end
         S_OUT:   state_d = S_IDLE;
         default: state_d = S_INIT;
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         cnt_q      <= '0;
         in_dat_q   <= '0;
         in_pend_q  <= 1'b0;
         req_pend_q <= 1'b0;
         stuff_q    <= 1'b0;
         x_q        <= '0;
         out_strobe <= 1'b0;
         out_data   <= '0;
      end else begin
         cnt_q <= cnt_d;
         if (in_take) begin
            in_dat_q  <= in_data;
            in_pend_q <= 1'b1;
         end else if (comb_start) begin
            in_pend_q <= 1'b0;
         end
         if (req_take)        req_pend_q <= 1'b1;
         else if (intg_start) req_pend_q <= 1'b0;
         if (comb_done)       stuff_q <= 1'b1;
         else if (intg_start) stuff_q <= 1'b0;
         // x_q carries the stage-to-stage value; after a comb pass it holds the comb output
         if (comb_start)                x_q <= {{(AW-24){in_dat_q[23]}}, in_dat_q};
         else if (state_q == S_COMB_RUN) x_q <= comb_y;
         else if (intg_start)           x_q <= stuff_q ? x_q : '0;
         else if (state_q == S_INTG_RUN) x_q <= intg_sum;
         out_strobe <= out_load;
         if (out_load) out_data <= intg_sum[AW-1 -: 24] + {23'd0, intg_sum[AW-25]};
      end
   end

`ifdef MEMCIC_INTERP_STATUS_EN
   logic ovr_evt, drop_evt;
   assign ovr_evt  = in_take && in_pend_q && !comb_start;
   assign drop_evt = req_take && req_pend_q && !intg_start;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         status <= '0;
      end else begin
         if (ovr_evt)         status[0] <= 1'b1;
         else if (status_clr) status[0] <= 1'b0;
         if (drop_evt)        status[1] <= 1'b1;
         else if (status_clr) status[1] <= 1'b0;
      end
   end
`endif

endmodule
